// File: rtl/bitrev_pkg.sv
// Shared types and the bit-reversal helper for the permutation sequencer.
// Pure definitions; no state, no timing, no flow control.
// Index width is fixed wide enough for any 4-bit log_n, so callers slice the result.
package bitrev_pkg;

  localparam int LOG_N_W   = 4;
  localparam int IDX_W_MAX = 17;
  localparam int SEL_W     = 5;

  typedef enum logic [2:0] {IDLE, SCAN, RD_A, RD_B, CAP_B, WR_A, WR_B, DONE} state_t;

  // Mirror bits [log_n-1:0] of idx; everything at and above log_n reads as zero.
  function automatic logic [IDX_W_MAX-1:0] bitrev(input logic [IDX_W_MAX-1:0] idx,
                                                  input logic [LOG_N_W-1:0]   log_n);
    logic [IDX_W_MAX-1:0] r;
    r = '0;
    for (int k = 0; k < IDX_W_MAX; k++) begin
      if (k < int'(log_n)) r[k] = idx[SEL_W'(int'(log_n) - 1 - k)];
    end
    return r;
  endfunction

endpackage

// File: rtl/bitrev_idx.sv
// Combinational bit-reversed index of idx over the low log_n bits.
// Latency: zero cycles, pure combinational.
// No flow control.
module bitrev_idx
  import bitrev_pkg::*;
#(
  parameter int LOG_N_MAX = 8
) (
  input  logic [LOG_N_MAX:0]   idx,
  input  logic [LOG_N_W-1:0]   log_n,
  output logic [LOG_N_MAX:0]   rev
);

  logic [IDX_W_MAX-1:0] rev_full;
  logic                 unused_rev_hi;

  always_comb rev_full = bitrev(IDX_W_MAX'(idx), log_n);

  assign rev           = rev_full[LOG_N_MAX:0];
  assign unused_rev_hi = ^rev_full[IDX_W_MAX-1:LOG_N_MAX+1];

endmodule

// File: rtl/bitrev_perm_ctrl.sv
// In-place bit-reversal permutation sequencer over one single-port RAM; swap_cnt port exists when BITREV_SWAP_CNT_EN is defined.
// Latency: N + 5*S + 1 busy cycles per run (S = swapped pairs); done pulses in the last of them.
// No backpressure: start is ignored while busy; RAM read data must arrive one cycle after the address.
module bitrev_perm_ctrl
  import bitrev_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int LOG_N_MAX = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [LOG_N_W-1:0]   log_n,
  output logic                 busy,
  output logic                 done,
  output logic                 cfg_err,
  output logic [LOG_N_MAX-1:0] mem_addr,
  output logic                 mem_we,
  output logic [DATA_W-1:0]    mem_wdata,
  input  logic [DATA_W-1:0]    mem_rdata
`ifdef BITREV_SWAP_CNT_EN
  ,
  output logic [LOG_N_MAX-1:0] swap_cnt
`endif
);

  state_t               state, state_nxt;
  logic [LOG_N_MAX:0]   idx, rev, n_last;
  logic [LOG_N_W-1:0]   ln;
  logic [DATA_W-1:0]    a_q, b_q;
  logic                 cfg_err_q;
  logic                 start_ok, is_last, do_swap;

  bitrev_idx #(.LOG_N_MAX(LOG_N_MAX)) u_rev (
    .idx   (idx),
    .log_n (ln),
    .rev   (rev)
  );

  assign start_ok = (log_n != '0) && (int'(log_n) <= LOG_N_MAX);
  // Counter is one bit wider than the address so N-1 at the largest size never wraps.
  assign n_last   = ((LOG_N_MAX+1)'(1) << ln) - (LOG_N_MAX+1)'(1);
  assign is_last  = (idx == n_last);
  assign do_swap  = (idx < rev);
  assign cfg_err  = cfg_err_q;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b1;
    done      = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start && start_ok) state_nxt = SCAN;
      end
      SCAN: begin
        if (do_swap)      state_nxt = RD_A;
        else if (is_last) state_nxt = DONE;
      end
      RD_A: begin
        mem_addr  = idx[LOG_N_MAX-1:0];
        state_nxt = RD_B;
      end
      RD_B: begin
        mem_addr  = rev[LOG_N_MAX-1:0];
        state_nxt = CAP_B;
      end
      CAP_B: state_nxt = WR_A;
      WR_A: begin
        mem_addr  = idx[LOG_N_MAX-1:0];
        mem_wdata = b_q;
        mem_we    = 1'b1;
        state_nxt = WR_B;
      end
      WR_B: begin
        mem_addr  = rev[LOG_N_MAX-1:0];
        mem_wdata = a_q;
        mem_we    = 1'b1;
        state_nxt = is_last ? DONE : SCAN;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx       <= '0;
      ln        <= '0;
      a_q       <= '0;
      b_q       <= '0;
      cfg_err_q <= 1'b0;
`ifdef BITREV_SWAP_CNT_EN
      swap_cnt  <= '0;
`endif
    end else begin
      cfg_err_q <= (state == IDLE) && start && !start_ok;
      case (state)
        IDLE: if (start && start_ok) begin
          ln  <= log_n;
          idx <= '0;
`ifdef BITREV_SWAP_CNT_EN
          swap_cnt <= '0;
`endif
        end
        SCAN:  if (!do_swap && !is_last) idx <= idx + (LOG_N_MAX+1)'(1);
        RD_B:  a_q <= mem_rdata;
        CAP_B: b_q <= mem_rdata;
        WR_B: begin
          if (!is_last) idx <= idx + (LOG_N_MAX+1)'(1);
`ifdef BITREV_SWAP_CNT_EN
          swap_cnt <= swap_cnt + LOG_N_MAX'(1);
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bitrev_perm_ctrl.sv
// Directed bench: a cycle-trace model of the RAM access pattern plus golden permutation checks.
module tb_bitrev_perm_ctrl;

  localparam int DATA_W    = 8;
  localparam int LOG_N_MAX = 8;
  localparam int MAXN      = 256;

  logic                 clk = 1'b0;
  logic                 rst, start;
  logic [3:0]           log_n;
  logic                 busy, done, cfg_err, mem_we;
  logic [LOG_N_MAX-1:0] mem_addr;
  logic [DATA_W-1:0]    mem_wdata, mem_rdata;
`ifdef BITREV_SWAP_CNT_EN
  logic [LOG_N_MAX-1:0] swap_cnt;
`endif

  always #5 clk = ~clk;

  bitrev_perm_ctrl #(.DATA_W(DATA_W), .LOG_N_MAX(LOG_N_MAX)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .log_n     (log_n),
    .busy      (busy),
    .done      (done),
    .cfg_err   (cfg_err),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
`ifdef BITREV_SWAP_CNT_EN
    ,
    .swap_cnt  (swap_cnt)
`endif
  );

  typedef struct {
    logic       busy;
    logic       done;
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] ram[MAXN];
  logic [7:0] init_mem[MAXN];
  logic [7:0] exp8[8];
  logic       load, clr, chk_en;
  int         checks, errors;
  int         wr_cnt, done_cnt, busy_cnt;
  int         wr_hits[MAXN];

  // Single-port RAM with one-cycle read latency.
  always @(posedge clk) begin
    mem_rdata <= ram[mem_addr];
    if (load) begin
      for (int k = 0; k < MAXN; k++) ram[k] <= init_mem[k];
    end else if (mem_we) begin
      ram[mem_addr] <= mem_wdata;
    end
  end

  always @(negedge clk) begin
    if (clr) begin
      wr_cnt   <= 0;
      done_cnt <= 0;
      busy_cnt <= 0;
      for (int k = 0; k < MAXN; k++) wr_hits[k] <= 0;
    end else begin
      if (mem_we) begin
        wr_cnt            <= wr_cnt + 1;
        wr_hits[mem_addr] <= wr_hits[mem_addr] + 1;
      end
      if (done) done_cnt <= done_cnt + 1;
      if (busy) busy_cnt <= busy_cnt + 1;
    end
  end

  function automatic int rev_ref(input int x, input int ln);
    int r = 0;
    for (int b = 0; b < ln; b++) r = (r << 1) | ((x >> b) & 1);
    return r;
  endfunction

  function automatic exp_t mk(input bit b, input bit d, input bit w, input int a, input logic [7:0] wd);
    exp_t e;
    e.busy = b; e.done = d; e.we = w; e.addr = 8'(a); e.wdata = wd;
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic prep();
    load = 1'b1; clr = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    load = 1'b0; clr = 1'b0;
  endtask

  // Expected cycle trace: one SCAN per index, five access cycles per swapped pair, then DONE.
  task automatic run(input int ln, input bit hold);
    int n, r;
    n = 1 << ln;
    prep();
    start = 1'b1; log_n = 4'(ln);
    @(posedge clk); #1;
    if (!hold) start = 1'b0;
    for (int i = 0; i < n; i++) begin
      r = rev_ref(i, ln);
      exp_q.push_back(mk(1, 0, 0, 0, 8'h0));
      if (i < r) begin
        exp_q.push_back(mk(1, 0, 0, i, 8'h0));
        exp_q.push_back(mk(1, 0, 0, r, 8'h0));
        exp_q.push_back(mk(1, 0, 0, 0, 8'h0));
        exp_q.push_back(mk(1, 0, 1, i, init_mem[r]));
        exp_q.push_back(mk(1, 0, 1, r, init_mem[i]));
      end
    end
    exp_q.push_back(mk(1, 1, 0, 0, 8'h0));
    if (hold) begin
      for (int c = 0; c < 5000 && exp_q.size() > 1; c++) begin
        @(posedge clk); #1;
      end
      start = 1'b0;
    end
    for (int c = 0; c < 5000 && exp_q.size() > 0; c++) @(negedge clk);
    if (exp_q.size() > 0) begin
      chk("drain_timeout", 32'(exp_q.size()), 0);
      exp_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic check_ram(input int ln);
    for (int k = 0; k < (1 << ln); k++)
      chk("ram_golden", 32'(ram[k]), 32'(init_mem[rev_ref(k, ln)]));
  endtask

  task automatic bad_start(input int ln);
    prep();
    start = 1'b1; log_n = 4'(ln);
    @(posedge clk); #1;
    start = 1'b0;
    chk("cfg_err_pulse", 32'(cfg_err), 1);
    chk("cfg_err_busy", 32'(busy), 0);
    @(posedge clk); #1;
    chk("cfg_err_clear", 32'(cfg_err), 0);
    @(negedge clk);
    chk("cfg_err_no_wr", 32'(wr_cnt), 0);
    chk("cfg_err_no_busy", 32'(busy_cnt), 0);
  endtask

  initial begin
    int  mx;
    bit  found;
    checks = 0; errors = 0;
    rst = 1'b1; start = 1'b0; log_n = '0;
    load = 1'b0; clr = 1'b1; chk_en = 1'b0;
    exp8 = '{8'd0, 8'd4, 8'd2, 8'd6, 8'd1, 8'd5, 8'd3, 8'd7};
    for (int k = 0; k < MAXN; k++) init_mem[k] = '0;

    fork
      forever begin
        exp_t e;
        @(negedge clk);
        if (chk_en) begin
          if (exp_q.size() > 0) e = exp_q.pop_front();
          else                  e = mk(0, 0, 0, 0, 8'h0);
          chk("cycle", 32'({busy, done, mem_we, mem_addr, mem_we ? mem_wdata : 8'h0}),
                       32'({e.busy, e.done, e.we, e.addr, e.wdata}));
        end
      end
    join_none

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_cfg_err", 32'(cfg_err), 0);
    chk("rst_we", 32'(mem_we), 0);
    chk("rst_addr", 32'(mem_addr), 0);
    chk("rst_wdata", 32'(mem_wdata), 0);
`ifdef BITREV_SWAP_CNT_EN
    chk("rst_swap_cnt", 32'(swap_cnt), 0);
`endif
    rst = 1'b0; clr = 1'b0; chk_en = 1'b1;

    // N=8 identity ramp.
    for (int k = 0; k < MAXN; k++) init_mem[k] = 8'(k);
    run(3, 0);
    for (int k = 0; k < 8; k++) chk("n8_ram", 32'(ram[k]), 32'(exp8[k]));
    chk("n8_writes", 32'(wr_cnt), 4);
    chk("n8_busy_cycles", 32'(busy_cnt), 19);
    chk("n8_done", 32'(done_cnt), 1);
`ifdef BITREV_SWAP_CNT_EN
    chk("n8_swap_cnt", 32'(swap_cnt), 2);
`endif

    // N=2: both indices palindromic.
    init_mem[0] = 8'd10; init_mem[1] = 8'd11;
    run(1, 0);
    chk("n2_ram0", 32'(ram[0]), 10);
    chk("n2_ram1", 32'(ram[1]), 11);
    chk("n2_writes", 32'(wr_cnt), 0);
    chk("n2_busy_cycles", 32'(busy_cnt), 3);
    chk("n2_done", 32'(done_cnt), 1);

    bad_start(0);
    bad_start(LOG_N_MAX + 1);

    // Largest size, random data.
    for (int k = 0; k < MAXN; k++) init_mem[k] = 8'($urandom_range(0, 255));
    run(LOG_N_MAX, 0);
    check_ram(LOG_N_MAX);
    mx = 0;
    for (int k = 0; k < MAXN; k++) if (wr_hits[k] > mx) mx = wr_hits[k];
    chk("n256_max_hits", 32'(mx), 1);
    chk("n256_writes", 32'(wr_cnt), 240);
    chk("n256_busy_cycles", 32'(busy_cnt), 857);
    chk("n256_done", 32'(done_cnt), 1);

    // start held high through the whole run.
    for (int k = 0; k < MAXN; k++) init_mem[k] = 8'($urandom_range(0, 255));
    run(4, 1);
    check_ram(4);
    chk("hold_done", 32'(done_cnt), 1);
    chk("hold_busy_cycles", 32'(busy_cnt), 47);
    chk("hold_writes", 32'(wr_cnt), 12);

    // Abort during WR_A of the second swap (i=3, rev=6).
    chk_en = 1'b0;
    for (int k = 0; k < MAXN; k++) init_mem[k] = 8'(k);
    prep();
    start = 1'b1; log_n = 4'd3;
    @(posedge clk); #1;
    start = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 60 && !found; c++) begin
      @(negedge clk);
      if (mem_we && mem_addr == 8'd3) found = 1'b1;
    end
    chk("abort_found_wr_a", 32'(found), 1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_we", 32'(mem_we), 0);
    chk("abort_addr", 32'(mem_addr), 0);
    chk("abort_wdata", 32'(mem_wdata), 0);
    chk("abort_done", 32'(done), 0);
    chk("abort_cfg_err", 32'(cfg_err), 0);
    repeat (3) @(negedge clk);
    chk("abort_no_done", 32'(done_cnt), 0);
    chk("abort_writes", 32'(wr_cnt), 3);
    chk("abort_ram1", 32'(ram[1]), 4);
    chk("abort_ram4", 32'(ram[4]), 1);
    chk("abort_ram3", 32'(ram[3]), 6);
    chk("abort_ram6", 32'(ram[6]), 6);
    rst = 1'b0;
    @(posedge clk); #1;
    chk_en = 1'b1;
    run(3, 0);
    check_ram(3);
    chk("rerun_done", 32'(done_cnt), 1);
`ifdef BITREV_SWAP_CNT_EN
    chk("rerun_swap_cnt", 32'(swap_cnt), 2);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
